uart_tx_engine: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_engine_if.sv | 24 ++
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_tx_engine.sv | 129 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame constants and
// peripheral register addresses used by the TX/RX engines and the bus block.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic [31:0] UART_TX_ADDR  = 32'h4000_0018;
    localparam logic [31:0] UART_RX_ADDR  = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Byte-level handshake between the UART peripheral and the TX engine.
// The peripheral is the master; the engine is the slave.
interface uart_tx_engine_if;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..DIV-1 and flags the last cycle of each bit.
// A synchronous clear restarts the period so each state starts in phase.
module uart_baud_cnt #(
    parameter int DIV = 16,
    parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         tick
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    assign tick = (count == LAST);

    // Free count within one bit period, restarted on clear or wrap.
    always_ff @(posedge sys_clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// Self-timed UART transmitter, 8N1 by default; defining UART_TX_PARITY_EN
// adds an even-parity bit for 8E1 framing.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DIV      = CLK_FREQ / BAUD
) (
    input  logic             sys_clk,
    input  logic             reset,
    uart_tx_engine_if.slave  tx_bus,
    output logic             uart_tx
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    // tx_done is registered, so it is set one cycle ahead of the stop bit's end.
    localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t         state;
    logic [7:0]        shift;
    logic [2:0]        bit_idx;
    logic              busy_q;
    logic              done_q;
    logic [CW-1:0]     baud_count;
    logic              tick;
    logic              clr;

`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    // Holding the counter clear in IDLE makes the start bit begin at count 0.
    assign clr = (state == TX_IDLE);

    assign tx_bus.tx_busy = busy_q;
    assign tx_bus.tx_done = done_q;

    uart_baud_cnt #(
        .DIV (DIV),
        .W   (CW)
    ) u_baud (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clr     (clr),
        .count   (baud_count),
        .tick    (tick)
    );

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state   <= TX_IDLE;
            shift   <= '0;
            bit_idx <= '0;
            uart_tx <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    uart_tx <= 1'b1;
                    if (tx_bus.tx_start) begin
                        shift   <= tx_bus.tx_data;
                        bit_idx <= '0;
                        uart_tx <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= TX_START;
`ifdef UART_TX_PARITY_EN
                        parity_q <= even_parity(tx_bus.tx_data);
`endif
                    end
                end
                TX_START: begin
                    if (tick) begin
                        uart_tx <= shift[0];
                        state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            uart_tx <= parity_q;
                            state   <= TX_PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= TX_STOP;
`endif
                        end else begin
                            uart_tx <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (tick) begin
                        uart_tx <= 1'b1;
                        state   <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (baud_count == PRE_LAST) begin
                        done_q <= 1'b1;
                    end
                    if (tick) begin
                        busy_q <= 1'b0;
                        state  <= TX_IDLE;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
